// File: rtl/bayer_pattern_gen_pkg.sv
// Shared types and constants for the synthetic Bayer pattern source:
// FSM states, pattern codes, LFSR seed/taps and the base pixel function.
package bayer_pattern_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PAT_FLAT  = 2'd0,
        PAT_HRAMP = 2'd1,
        PAT_VBARS = 2'd2,
        PAT_HBARS = 2'd3
    } pattern_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as a mask over state bits [15],[13],[12],[10]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Same value on every Bayer site, so only the column bits and row bit 4 matter.
    function automatic logic [11:0] pixel_value(input pattern_t pat,
                                                input logic [9:0] x,
                                                input logic y4);
        logic [11:0] value;
        case (pat)
            PAT_FLAT:  value = 12'h800;
            PAT_HRAMP: value = {x, 2'b00};
            PAT_VBARS: value = x[4] ? 12'hFFF : 12'h000;
            default:   value = y4 ? 12'hFFF : 12'h000;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/bayer_pattern_lfsr.sv
// 16-bit Fibonacci LFSR used to dither generated pixels; advances only when en is high.
module bayer_pattern_lfsr
    import bayer_pattern_gen_pkg::*;
(
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        en,
    output logic [15:0] lfsr_state
);

    logic [15:0] state_reg;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_reg <= LFSR_SEED;
        end else if (en) begin
            state_reg <= {state_reg[14:0], ^(state_reg & LFSR_TAPS)};
        end
    end

    assign lfsr_state = state_reg;

endmodule

// File: rtl/bayer_pattern_gen.sv
// Synthetic raw Bayer stream source with DVAL strobe and X/Y counters.
// Define BAYER_PATTERN_GEN_NOISE_EN to add saturating LFSR dither to each pixel.
module bayer_pattern_gen
    import bayer_pattern_gen_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 960,
    parameter int H_BLANK  = 32,
    parameter int V_BLANK  = 64
)
(
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iCLKEN,
    input  logic        iRun,
    input  logic [1:0]  iPattern,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont,
    output logic        oFrameDone,
    output logic [15:0] oFrame_Cont
);

    localparam logic [10:0] X_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST  = 11'(V_ACTIVE - 1);
    localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);

    state_t      state_reg, state_next;
    pattern_t    pat_reg, pat_next;
    logic [10:0] x_reg, x_next, y_reg, y_next;
    logic [15:0] blank_reg, blank_next;
    logic [11:0] data_reg, data_next;
    logic        dval_reg, dval_next;
    logic [10:0] x_out_reg, x_out_next, y_out_reg, y_out_next;
    logic        done_reg, done_next;
    logic [15:0] fcnt_reg, fcnt_next;
    logic [11:0] base_pixel, pixel;

    assign base_pixel = pixel_value(pat_reg, x_reg[9:0], y_reg[4]);

`ifdef BAYER_PATTERN_GEN_NOISE_EN
    logic [15:0] lfsr_state;
    logic [12:0] noisy_sum;

    bayer_pattern_lfsr u_lfsr (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .en         (iCLKEN && (state_reg == ST_ACTIVE)),
        .lfsr_state (lfsr_state)
    );

    assign noisy_sum = {1'b0, base_pixel} + {9'd0, lfsr_state[3:0]};
    assign pixel     = noisy_sum[12] ? 12'hFFF : noisy_sum[11:0];
`else
    assign pixel = base_pixel;
`endif

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_reg <= ST_IDLE;
            pat_reg   <= PAT_FLAT;
            x_reg     <= '0;
            y_reg     <= '0;
            blank_reg <= '0;
            data_reg  <= '0;
            dval_reg  <= 1'b0;
            x_out_reg <= '0;
            y_out_reg <= '0;
            done_reg  <= 1'b0;
            fcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pat_reg   <= pat_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            blank_reg <= blank_next;
            data_reg  <= data_next;
            dval_reg  <= dval_next;
            x_out_reg <= x_out_next;
            y_out_reg <= y_out_next;
            done_reg  <= done_next;
            fcnt_reg  <= fcnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pat_next   = pat_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        blank_next = blank_reg;
        data_next  = data_reg;
        dval_next  = 1'b0;
        x_out_next = x_out_reg;
        y_out_next = y_out_reg;
        done_next  = 1'b0;
        fcnt_next  = fcnt_reg;
        if (iCLKEN) begin
            case (state_reg)
                ST_IDLE: begin
                    x_out_next = '0;
                    y_out_next = '0;
                    if (iRun) begin
                        state_next = ST_ACTIVE;
                        pat_next   = pattern_t'(iPattern);
                        x_next     = '0;
                        y_next     = '0;
                    end
                end
                ST_ACTIVE: begin
                    dval_next  = 1'b1;
                    data_next  = pixel;
                    x_out_next = x_reg;
                    y_out_next = y_reg;
                    blank_next = '0;
                    if (x_reg == X_LAST) begin
                        x_next = '0;
                        if (y_reg == Y_LAST) begin
                            state_next = ST_VBLANK;
                            done_next  = 1'b1;
                            fcnt_next  = fcnt_reg + 16'd1;
                        end else begin
                            state_next = ST_HBLANK;
                        end
                    end else begin
                        x_next = x_reg + 11'd1;
                    end
                end
                ST_HBLANK: begin
                    // Row stays on oY_Cont while the line is blanked
                    x_out_next = '0;
                    if (blank_reg == HB_LAST) begin
                        state_next = ST_ACTIVE;
                        y_next     = y_reg + 11'd1;
                        blank_next = '0;
                    end else begin
                        blank_next = blank_reg + 16'd1;
                    end
                end
                default: begin
                    x_out_next = '0;
                    y_out_next = '0;
                    if (blank_reg == VB_LAST) begin
                        blank_next = '0;
                        x_next     = '0;
                        y_next     = '0;
                        if (iRun) begin
                            state_next = ST_ACTIVE;
                            pat_next   = pattern_t'(iPattern);
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        blank_next = blank_reg + 16'd1;
                    end
                end
            endcase
        end
    end

    assign oDATA       = data_reg;
    assign oDVAL       = dval_reg;
    assign oX_Cont     = x_out_reg;
    assign oY_Cont     = y_out_reg;
    assign oFrameDone  = done_reg;
    assign oFrame_Cont = fcnt_reg;

endmodule

// File: tb/tb_bayer_pattern_gen.sv
// Self-checking bench for bayer_pattern_gen: table of frame scenarios plus hand-written
// corner sequences, every cycle compared with a frame-position reference model.
module tb_bayer_pattern_gen;

    localparam int HA = 40;
    localparam int VA = 36;
    localparam int HB = 2;
    localparam int VB = 3;
    localparam int L  = HA + HB;
    localparam int ACTIVE_SPAN = VA * L - HB;   // enabled edges from first to past last pixel
    localparam int P  = ACTIVE_SPAN + VB;       // frame period in enabled edges

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clken;
    logic        run_i;
    logic [1:0]  pat_i;
    logic [11:0] oDATA;
    logic        oDVAL;
    logic [10:0] oX_Cont, oY_Cont;
    logic        oFrameDone;
    logic [15:0] oFrame_Cont;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    bayer_pattern_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB)) dut (
        .iCLK        (clk),
        .iRST        (rst_n),
        .iCLKEN      (clken),
        .iRun        (run_i),
        .iPattern    (pat_i),
        .oDATA       (oDATA),
        .oDVAL       (oDVAL),
        .oX_Cont     (oX_Cont),
        .oY_Cont     (oY_Cont),
        .oFrameDone  (oFrameDone),
        .oFrame_Cont (oFrame_Cont)
    );

    always #5 clk = ~clk;

    // Reference model: position inside the frame is a single edge index t.
    bit          m_idle;
    int          m_t;
    int          m_pat;
    logic [11:0] m_data;
    logic        m_dval, m_done;
    logic [10:0] m_x, m_y;
    logic [15:0] m_fcnt;

    function automatic logic [11:0] ref_pixel(input int pat, input int x, input int y);
        case (pat)
            0:       return 12'h800;
            1:       return 12'((x * 4) % 4096);
            2:       return ((x / 16) % 2 == 1) ? 12'hFFF : 12'h000;
            default: return ((y / 16) % 2 == 1) ? 12'hFFF : 12'h000;
        endcase
    endfunction

    task automatic model_reset();
        m_idle = 1'b1; m_t = 0; m_pat = 0;
        m_data = '0; m_dval = 1'b0; m_done = 1'b0;
        m_x = '0; m_y = '0; m_fcnt = '0;
    endtask

    task automatic model_edge(input bit en, input bit run, input int pat);
        int line, col;
        m_dval = 1'b0;
        m_done = 1'b0;
        if (!en) return;
        if (m_idle) begin
            m_x = '0; m_y = '0;
            if (run) begin m_idle = 1'b0; m_t = 0; m_pat = pat; end
        end else begin
            if (m_t < ACTIVE_SPAN) begin
                line = m_t / L;
                col  = m_t % L;
                m_y  = 11'(line);
                if (col < HA) begin
                    m_dval = 1'b1;
                    m_data = ref_pixel(m_pat, col, line);
                    m_x    = 11'(col);
                    if (m_t == ACTIVE_SPAN - 1) begin
                        m_done = 1'b1;
                        m_fcnt = m_fcnt + 16'd1;
                    end
                end else begin
                    m_x = '0;
                end
            end else begin
                m_x = '0; m_y = '0;
            end
            if (m_t == P - 1) begin
                if (run) begin m_t = 0; m_pat = pat; end
                else m_idle = 1'b1;
            end else begin
                m_t++;
            end
        end
    endtask

    task automatic check_outputs();
        total++;
        if (oDATA !== m_data || oDVAL !== m_dval || oX_Cont !== m_x || oY_Cont !== m_y ||
            oFrameDone !== m_done || oFrame_Cont !== m_fcnt) begin
            bad++;
            $display("FAIL stream cyc=%0d got data=%h dval=%b x=%0d y=%0d done=%b fcnt=%0d required data=%h dval=%b x=%0d y=%0d done=%b fcnt=%0d",
                     cycle, oDATA, oDVAL, oX_Cont, oY_Cont, oFrameDone, oFrame_Cont,
                     m_data, m_dval, m_x, m_y, m_done, m_fcnt);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic tick(input bit en, input bit run, input logic [1:0] pat);
        clken = en; run_i = run; pat_i = pat;
        @(posedge clk);
        cycle++;
        model_edge(en, run, int'(pat));
        #1;
        check_outputs();
    endtask

    // Drop iRun and let the current frame finish; returns DVAL pulses seen meanwhile.
    task automatic wind_down(input bit toggle, output int pix);
        int n = 0;
        pix = 0;
        while (!m_idle && n < 4 * P) begin
            tick(toggle ? (n % 2 == 0) : 1'b1, 1'b0, 2'd0);
            if (oDVAL) pix++;
            n++;
        end
        check_val("wind_down_timeout", int'(m_idle), 1);
    endtask

    typedef struct {
        logic [1:0] pat;
        bit         toggle;
        int         nframes;
        int         exp_pixels;
        int         exp_interval;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input int idx, input vec_t v);
        int pix = 0, dones = 0, last_done = -1, interval = -1, consec = 0, cyc = 0, extra;
        bit prev = 1'b0;
        logic [15:0] f0 = oFrame_Cont;
        int budget = (v.nframes + 2) * P * 2 + 100;
        while (dones < v.nframes && cyc < budget) begin
            tick(v.toggle ? (cyc % 2 == 0) : 1'b1, 1'b1, v.pat);
            cyc++;
            if (oDVAL) begin pix++; if (prev) consec++; end
            prev = oDVAL;
            if (oFrameDone) begin
                if (last_done >= 0) interval = cyc - last_done;
                last_done = cyc;
                dones++;
            end
        end
        check_val("vec_frame_timeout", dones, v.nframes);
        wind_down(v.toggle, extra);
        check_val("vec_pixels", pix + extra, v.exp_pixels);
        check_val("vec_frames", int'(16'(oFrame_Cont - f0)), v.nframes);
        if (v.nframes >= 2) check_val("vec_interval", interval, v.exp_interval);
        if (v.toggle) check_val("vec_consec_dval", consec, 0);
        $display("vec %0d pat=%0d toggle=%0d frames=%0d pixels=%0d interval=%0d",
                 idx, v.pat, v.toggle, dones, pix + extra, interval);
    endtask

    initial begin
        int n, extra, dones, pix, lat;
        logic [15:0] f0;

        rst_n = 1'b0; clken = 1'b0; run_i = 1'b0; pat_i = 2'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_data", int'(oDATA), 0);
        check_val("reset_dval", int'(oDVAL), 0);
        check_val("reset_xy", int'({oX_Cont, oY_Cont}), 0);
        check_val("reset_done_fcnt", int'({oFrameDone, oFrame_Cont}), 0);
        rst_n = 1'b1;
        $display("reset released");

        vecs[0] = '{2'd0, 1'b0, 1, HA * VA,     0};
        vecs[1] = '{2'd1, 1'b0, 2, 2 * HA * VA, P};
        vecs[2] = '{2'd2, 1'b0, 1, HA * VA,     0};
        vecs[3] = '{2'd3, 1'b1, 2, 2 * HA * VA, 2 * P};
        vecs[4] = '{2'(($urandom % 4)), 1'b1, 1, HA * VA, 0};
        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Pattern switched mid-frame only takes effect on the following frame.
        n = 0; dones = 0;
        while (!(m_dval && m_y == 11'd5) && n < P) begin tick(1'b1, 1'b1, 2'd2); n++; end
        while (dones < 2 && n < 4 * P) begin
            tick(1'b1, 1'b1, 2'd3);
            n++;
            if (oDVAL && dones == 0 && oX_Cont == 11'd20 && oY_Cont == 11'd20)
                check_val("vbars_kept_x20", int'(oDATA), 12'hFFF);
            if (oDVAL && dones == 0 && oX_Cont == 11'd0 && oY_Cont == 11'd20)
                check_val("vbars_kept_x0", int'(oDATA), 12'h000);
            if (oDVAL && dones == 1 && oX_Cont == 11'd0 && oY_Cont == 11'd20)
                check_val("hbars_next_row20", int'(oDATA), 12'hFFF);
            if (oDVAL && dones == 1 && oX_Cont == 11'd20 && oY_Cont == 11'd5)
                check_val("hbars_next_row5", int'(oDATA), 12'h000);
            if (oFrameDone) dones++;
        end
        check_val("switch_frames", dones, 2);
        wind_down(1'b0, extra);
        $display("pattern switch sequence frames=%0d", dones);

        // iRun dropped mid-frame: frame completes, then generator idles.
        f0 = oFrame_Cont;
        for (int i = 0; i < P / 2; i++) tick(1'b1, 1'b1, 2'd1);
        n = 0; dones = 0;
        while (dones == 0 && n < P) begin
            tick(1'b1, 1'b0, 2'd1);
            n++;
            if (oFrameDone) dones++;
        end
        check_val("rundrop_done_seen", dones, 1);
        wind_down(1'b0, extra);
        pix = 0;
        for (int i = 0; i < 20; i++) begin tick(1'b1, 1'b0, 2'd1); if (oDVAL) pix++; end
        check_val("rundrop_idle_dval", pix, 0);
        check_val("rundrop_frames", int'(16'(oFrame_Cont - f0)), 1);
        $display("run drop sequence frames=%0d idle_pixels=%0d", dones, pix);

        // Reset at pixel (3,2): outputs clear at once, restart at (0,0) with count 0.
        n = 0;
        while (!(oDVAL && oX_Cont == 11'd3 && oY_Cont == 11'd2) && n < P) begin
            tick(1'b1, 1'b1, 2'd1); n++;
        end
        check_val("reset_target_reached", int'(oDVAL && oX_Cont == 11'd3 && oY_Cont == 11'd2), 1);
        rst_n = 1'b0;
        #1;
        check_val("midreset_data_dval", int'({oDATA, oDVAL}), 0);
        check_val("midreset_xy", int'({oX_Cont, oY_Cont}), 0);
        check_val("midreset_fcnt", int'(oFrame_Cont), 0);
        model_reset();
        #2 rst_n = 1'b1;
        lat = 0;
        while (!oDVAL && lat < 10) begin tick(1'b1, 1'b1, 2'd1); lat++; end
        check_val("restart_latency", lat, 2);
        check_val("restart_xy", int'({oX_Cont, oY_Cont}), 0);
        check_val("restart_fcnt", int'(oFrame_Cont), 0);
        wind_down(1'b0, extra);
        $display("mid-frame reset sequence latency=%0d", lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
